// File: rtl/imem_access_controller.sv
// Arbitrates the single-port instruction memory between the loader/debug write
// port and the fetch stage, with boot sequencing and a bounded write-starvation guard.
module imem_access_controller #(
   parameter int WIDTH        = 32,
   parameter int DEPTH        = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ld_valid,
   input  logic [WIDTH-1:0]           ld_addr,
   input  logic [WIDTH-1:0]           ld_data,
   output logic                       ld_ready,
   input  logic                       ld_done,
   output logic                       boot_done,
   output logic                       ld_error,
   output logic [$clog2(DEPTH):0]     loaded_count,
   input  logic                       fetch_req,
   input  logic [WIDTH-1:0]           fetch_pc,
   output logic                       fetch_gnt,
   input  logic                       flush,
   output logic                       instr_valid,
   output logic [WIDTH-1:0]           instr_out,
   output logic                       fetch_fault,
   output logic [WIDTH-1:0]           mem_addr,
   output logic                       mem_we,
   output logic                       mem_fe,
   output logic [WIDTH-1:0]           mem_wdata,
   input  logic [WIDTH-1:0]           mem_rdata
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

   localparam logic [WIDTH-1:0] DEPTH_W    = WIDTH'(DEPTH);
   localparam logic [CNT_W-1:0] COUNT_MAX  = CNT_W'(DEPTH);
   localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE_LIMIT);

   localparam logic [0:0] ST_BOOT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]       state;
   logic             isRun;
   logic [SC_W-1:0]  starveCnt;
   logic [CNT_W-1:0] loadedCount;
   logic             ldError;
   logic             forceWr;
   logic             ldReadyC;
   logic             fetchGntC;
   logic             wrOk;
   logic             feOk;
   logic             vld_p1;
   logic             fault_p1;

   function automatic logic inRange(input logic [WIDTH-1:0] a);
      return a < DEPTH_W;
   endfunction

   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
      return (c >= COUNT_MAX) ? c : c + CNT_W'(1);
   endfunction

   assign isRun = (state == ST_RUN);

   // Grant decision: reset blocks every grant; BOOT serves only the loader;
   // RUN favours fetch until the starve counter forces the write through.
   always_comb begin
      forceWr   = 1'b0;
      ldReadyC  = 1'b0;
      fetchGntC = 1'b0;
      if (!rst) begin
         if (isRun) begin
            forceWr   = ld_valid && (starveCnt == STARVE_MAX);
            fetchGntC = fetch_req && !forceWr;
            ldReadyC  = (ld_valid && !fetch_req) || forceWr;
         end else begin
            ldReadyC  = ld_valid;
         end
      end
   end

   // Grants are mutually exclusive above, so mem_we and mem_fe can never overlap.
   always_comb begin
      wrOk      = ldReadyC && inRange(ld_addr);
      feOk      = fetchGntC && inRange(fetch_pc);
      mem_we    = wrOk;
      mem_fe    = feOk;
      mem_addr  = '0;
      mem_wdata = '0;
      if (wrOk) begin
         mem_addr  = ld_addr;
         mem_wdata = ld_data;
      end else if (feOk) begin
         mem_addr  = fetch_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_BOOT;
         starveCnt   <= '0;
         loadedCount <= '0;
         ldError     <= 1'b0;
      end else begin
         if (ldReadyC && !inRange(ld_addr))
            ldError <= 1'b1;
         if (!isRun) begin
            if (wrOk)
               loadedCount <= satInc(loadedCount);
            if (ld_done)
               state <= ST_RUN;
         end
         if (!isRun || !ld_valid || ldReadyC)
            starveCnt <= '0;
         else if (fetch_req && (starveCnt != STARVE_MAX))
            starveCnt <= starveCnt + SC_W'(1);
      end
   end

   // Stage p0 -> p1: the memory returns read data one cycle after mem_fe.
   // A flush in the grant cycle kills that response.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1   <= 1'b0;
         fault_p1 <= 1'b0;
      end else begin
         vld_p1   <= fetchGntC && !flush;
         fault_p1 <= fetchGntC && !flush && !inRange(fetch_pc);
      end
   end

   assign ld_ready     = ldReadyC;
   assign fetch_gnt    = fetchGntC;
   assign boot_done    = isRun;
   assign ld_error     = ldError;
   assign loaded_count = loadedCount;
   assign instr_valid  = vld_p1;
   assign fetch_fault  = vld_p1 && fault_p1;
   assign instr_out    = fault_p1 ? '0 : mem_rdata;

endmodule

// File: tb/tb_imem_access_controller.sv
// Directed bench for imem_access_controller with a small synchronous memory model.
module tb_imem_access_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        ld_valid;
   logic [31:0] ld_addr;
   logic [31:0] ld_data;
   logic        ld_ready;
   logic        ld_done;
   logic        boot_done;
   logic        ld_error;
   logic [4:0]  loaded_count;
   logic        fetch_req;
   logic [31:0] fetch_pc;
   logic        fetch_gnt;
   logic        flush;
   logic        instr_valid;
   logic [31:0] instr_out;
   logic        fetch_fault;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic        mem_fe;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] memArr [0:15];
   int testsRun = 0;
   int failCount = 0;

   always #5 clk = ~clk;

   imem_access_controller #(.WIDTH(32), .DEPTH(16), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
      .ld_done(ld_done), .boot_done(boot_done), .ld_error(ld_error),
      .loaded_count(loaded_count),
      .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_gnt(fetch_gnt), .flush(flush),
      .instr_valid(instr_valid), .instr_out(instr_out), .fetch_fault(fetch_fault),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_fe(mem_fe),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Synchronous single-port instruction memory
   always @(posedge clk) begin
      if (mem_we) memArr[mem_addr[3:0]] <= mem_wdata;
      if (mem_fe) mem_rdata <= memArr[mem_addr[3:0]];
   end

   task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         failCount++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic idleInputs();
      ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
      fetch_req = 1'b0; fetch_pc = '0; flush = 1'b0;
   endtask

   task automatic nextCycle();
      @(negedge clk);
      idleInputs();
   endtask

   initial begin
      for (int i = 0; i < 16; i++) memArr[i] = '0;
      mem_rdata = '0;
      rst = 1'b1;
      idleInputs();

      // Reset cycle with both requesters active: nothing may be granted
      nextCycle();
      rst = 1'b1; fetch_req = 1'b1; ld_valid = 1'b1; ld_addr = 32'd1; ld_data = 32'h99;
      #1;
      checkVal("rst_fetch_gnt", 32'(fetch_gnt), 32'd0);
      checkVal("rst_ld_ready", 32'(ld_ready), 32'd0);
      checkVal("rst_mem_we", 32'(mem_we), 32'd0);
      checkVal("rst_mem_fe", 32'(mem_fe), 32'd0);

      nextCycle();
      rst = 1'b0;
      #1;
      checkVal("rst_boot_done", 32'(boot_done), 32'd0);
      checkVal("rst_instr_valid", 32'(instr_valid), 32'd0);
      checkVal("rst_ld_error", 32'(ld_error), 32'd0);
      checkVal("rst_loaded_count", 32'(loaded_count), 32'd0);

      // Out-of-range write in BOOT
      nextCycle();
      ld_valid = 1'b1; ld_addr = 32'd16; ld_data = 32'hDEAD;
      #1;
      checkVal("oor_boot_ready", 32'(ld_ready), 32'd1);
      checkVal("oor_boot_we", 32'(mem_we), 32'd0);
      nextCycle();
      #1;
      checkVal("oor_boot_err", 32'(ld_error), 32'd1);
      checkVal("oor_boot_count", 32'(loaded_count), 32'd0);
      checkVal("oor_boot_mem_addr", mem_addr, 32'd0);
      checkVal("oor_boot_mem_wdata", mem_wdata, 32'd0);

      // Load words 0..3, ld_done with the last write; fetch requested but refused
      for (int i = 0; i < 4; i++) begin
         nextCycle();
         ld_valid = 1'b1; ld_addr = 32'(i); ld_data = 32'h11 * 32'(i + 1);
         fetch_req = 1'b1; fetch_pc = 32'd0;
         ld_done = (i == 3);
         #1;
         checkVal("boot_fetch_gnt", 32'(fetch_gnt), 32'd0);
         checkVal("boot_ld_ready", 32'(ld_ready), 32'd1);
         checkVal("boot_mem_we", 32'(mem_we), 32'd1);
         checkVal("boot_mem_addr", mem_addr, 32'(i));
         checkVal("boot_mem_wdata", mem_wdata, 32'h11 * 32'(i + 1));
         checkVal("boot_done_low", 32'(boot_done), 32'd0);
      end
      nextCycle();
      #1;
      checkVal("load_count", 32'(loaded_count), 32'd4);
      checkVal("boot_done_high", 32'(boot_done), 32'd1);
      checkVal("err_sticky", 32'(ld_error), 32'd1);

      // Back-to-back fetches of 0..3
      for (int i = 0; i < 5; i++) begin
         nextCycle();
         if (i < 4) begin
            fetch_req = 1'b1; fetch_pc = 32'(i);
         end
         #1;
         if (i < 4) begin
            checkVal("run_fetch_gnt", 32'(fetch_gnt), 32'd1);
            checkVal("run_mem_fe", 32'(mem_fe), 32'd1);
            checkVal("run_mem_addr", mem_addr, 32'(i));
         end
         checkVal("run_mem_we", 32'(mem_we), 32'd0);
         if (i > 0) begin
            checkVal("run_instr_valid", 32'(instr_valid), 32'd1);
            checkVal("run_instr_out", instr_out, 32'h11 * 32'(i));
            checkVal("run_fault_low", 32'(fetch_fault), 32'd0);
         end
      end

      // Out-of-range fetch
      nextCycle();
      fetch_req = 1'b1; fetch_pc = 32'd20;
      #1;
      checkVal("oor_fetch_gnt", 32'(fetch_gnt), 32'd1);
      checkVal("oor_fetch_fe", 32'(mem_fe), 32'd0);
      nextCycle();
      #1;
      checkVal("oor_fetch_valid", 32'(instr_valid), 32'd1);
      checkVal("oor_fetch_nop", instr_out, 32'd0);
      checkVal("oor_fetch_fault", 32'(fetch_fault), 32'd1);
      nextCycle();
      #1;
      checkVal("idle_valid", 32'(instr_valid), 32'd0);
      checkVal("idle_fault", 32'(fetch_fault), 32'd0);

      // Starvation: write forced through on the fifth blocked cycle
      for (int i = 0; i < 5; i++) begin
         nextCycle();
         fetch_req = 1'b1; fetch_pc = 32'd0;
         ld_valid = 1'b1; ld_addr = 32'd5; ld_data = 32'hABCD;
         #1;
         if (i < 4) begin
            checkVal("starve_fetch_gnt", 32'(fetch_gnt), 32'd1);
            checkVal("starve_ld_ready", 32'(ld_ready), 32'd0);
         end else begin
            checkVal("force_fetch_gnt", 32'(fetch_gnt), 32'd0);
            checkVal("force_ld_ready", 32'(ld_ready), 32'd1);
            checkVal("force_mem_we", 32'(mem_we), 32'd1);
            checkVal("force_mem_fe", 32'(mem_fe), 32'd0);
            checkVal("force_mem_addr", mem_addr, 32'd5);
         end
      end
      nextCycle();
      fetch_req = 1'b1; fetch_pc = 32'd5;
      #1;
      checkVal("after_force_gnt", 32'(fetch_gnt), 32'd1);
      checkVal("after_force_valid", 32'(instr_valid), 32'd0);
      nextCycle();
      #1;
      checkVal("readback_valid", 32'(instr_valid), 32'd1);
      checkVal("readback_data", instr_out, 32'hABCD);
      checkVal("run_count_frozen", 32'(loaded_count), 32'd4);

      // Flush one cycle after the grant leaves that response alone
      nextCycle();
      fetch_req = 1'b1; fetch_pc = 32'd1;
      nextCycle();
      fetch_req = 1'b1; fetch_pc = 32'd2; flush = 1'b1;
      #1;
      checkVal("flush_late_valid", 32'(instr_valid), 32'd1);
      checkVal("flush_late_data", instr_out, 32'h22);
      nextCycle();
      #1;
      checkVal("flush_late_kill", 32'(instr_valid), 32'd0);

      // Flush in the grant cycle suppresses the next-cycle response
      nextCycle();
      fetch_req = 1'b1; fetch_pc = 32'd3; flush = 1'b1;
      #1;
      checkVal("flush_same_gnt", 32'(fetch_gnt), 32'd1);
      nextCycle();
      #1;
      checkVal("flush_same_kill", 32'(instr_valid), 32'd0);

      // RUN: out-of-range write dropped, ld_done ignored
      nextCycle();
      ld_valid = 1'b1; ld_addr = 32'd16; ld_data = 32'h77; ld_done = 1'b1;
      #1;
      checkVal("oor_run_ready", 32'(ld_ready), 32'd1);
      checkVal("oor_run_we", 32'(mem_we), 32'd0);
      nextCycle();
      #1;
      checkVal("run_still_booted", 32'(boot_done), 32'd1);
      checkVal("run_err", 32'(ld_error), 32'd1);

      // Reset with a fetch in flight
      nextCycle();
      fetch_req = 1'b1; fetch_pc = 32'd0;
      #1;
      checkVal("pre_rst_gnt", 32'(fetch_gnt), 32'd1);
      nextCycle();
      rst = 1'b1; fetch_req = 1'b1; fetch_pc = 32'd1;
      #1;
      checkVal("mid_rst_gnt", 32'(fetch_gnt), 32'd0);
      checkVal("mid_rst_fe", 32'(mem_fe), 32'd0);
      nextCycle();
      rst = 1'b0; fetch_req = 1'b1; fetch_pc = 32'd1;
      #1;
      checkVal("post_rst_valid", 32'(instr_valid), 32'd0);
      checkVal("post_rst_boot", 32'(boot_done), 32'd0);
      checkVal("post_rst_err", 32'(ld_error), 32'd0);
      checkVal("post_rst_count", 32'(loaded_count), 32'd0);
      checkVal("post_rst_gnt", 32'(fetch_gnt), 32'd0);

      nextCycle();
      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
